add_share_seq: RTL and testbench
================================

# add_share_seq

Sequencer and arbiter that shares one 8-bit combinational adder (the team's carry-select adder) between two requesters and performs multi-byte additions on it. It accepts one 8·NBYTES-bit add request at a time, round-robin between requesters. It then streams the operands through the adder one byte per cycle, LSB first, chaining the carry in a register. It returns the full sum and carry-out with a one-cycle done pulse tagged with the requester ID.

## Interface
- NBYTES, 4, number of byte slices per operand (operand width W = 8·NBYTES); legal range 2..8
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req0, req1  in  1  request from requester 0 / 1, level
- a0, b0, a1, b1  in  W  operands for requester 0 / 1
- cin0, cin1  in  1  carry-in for requester 0 / 1
- gnt0, gnt1  out  1  one-cycle acceptance pulse to requester 0 / 1
- busy  out  1  high while a transaction is in progress (RUN or DONE)
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester ID of the completed transaction, valid with done, held until next done
- result  out  W  sum, held until next done
- cout  out  1  final carry, held until next done
- add_a, add_b  out  8  byte slice to the shared adder
- add_cin  out  1  carry to the shared adder
- add_sum  in  8  adder sum, combinational from add_a/add_b/add_cin
- add_cout  in  1  adder carry-out

## Operation
- Reset values: gnt0=gnt1=busy=done=done_id=cout=0; result=0; add_a=add_b=0; add_cin=0. Internal state: IDLE, byte index=0, last-grant=1, which makes requester 0 win the first tie.
- FSM states:
  - IDLE: on a clock edge with req0|req1 high, pick the winner. If only one requests, that one wins. If both request, the winner is the requester not in last-grant. On selection, latch its a, b and cin into internal registers, set the carry register to cin, set index=0, update last-grant, and go to RUN.
  - RUN: for index k, drive add_a=A[8k+7:8k], add_b=B[8k+7:8k], add_cin=carry. At the edge, write add_sum into the internal sum byte k and load add_cout into the carry register. Increment k. After k=NBYTES-1, go to DONE.
  - DONE: for one cycle, result=internal sum, cout=carry, done=1, done_id=winner. Then go to IDLE.
- add_a, add_b and add_cin are 0 outside RUN.
- Operands are sampled only at the accept edge. Input changes afterward have no effect on the transaction.
- Requests arriving during RUN or DONE are not accepted until IDLE. A request held high through completion is served again, alternating with the other requester if both stay high.
- gnt is asserted during the first RUN cycle for the winner. A requester must hold req and operands stable until it sees gnt.
- Arithmetic is unsigned modulo 2^W. cout is the carry out of bit W-1.
- Reset mid-transaction aborts immediately: no done pulse, all outputs return to reset values, and last-grant returns to 1.

## Timing
- Accept at edge E0 (req high in IDLE).
- RUN occupies the cycles after edges E0..E(NBYTES-1); gnt is high in the cycle after E0.
- DONE is the cycle after edge E(NBYTES); done, result and cout are visible in that cycle. With NBYTES=4, done is high in the 5th cycle after the accept edge.
- Back to IDLE after edge E(NBYTES+1). The earliest next accept is at edge E(NBYTES+1), so the period is NBYTES+1 cycles per back-to-back transaction: the IDLE-evaluated accept coincides with the DONE→IDLE edge. Implementation must accept in that same edge: the DONE→IDLE transition evaluates the requests and goes directly to RUN if any are pending.
- All outputs are registered except add_a, add_b and add_cin, which are decoded from registered state and index.

## Test plan
- Single req0, a0=0x000000FF, b0=0x00000001, cin0=0 → gnt0 pulse 1 cycle after accept; done 5 cycles after accept; result=0x00000100, cout=0, done_id=0.
- req1, a1=0xFFFFFFFF, b1=0x00000000, cin1=1 → result=0x00000000, cout=1, done_id=1. Check add_cin is 1 in every RUN cycle.
- req0 and req1 held high from reset with distinct operands → order of done_id is 0,1,0,1. Consecutive done pulses are 5 cycles apart. Each result matches its own operands.
- After accept, change a0 to 0x12345678 → result still reflects the operands latched at accept.
- Assert rst_n low during the 3rd RUN cycle → no done pulse; all outputs 0 asynchronously. After release, req1 and req0 together → req0 granted first.
- Byte sequencing with a0=0x04030201, b0=0x40302010 → add_a/add_b are 01/10, 02/20, 03/30, 04/40 in consecutive cycles; result=0x44332211.

Source files
------------

// File: rtl/add_share_seq.sv
// Round-robin sequencer sharing one external 8-bit adder between two requesters for
// multi-byte adds, LSB byte first with a registered carry chain; one result per NBYTES+1 cycles.
module add_share_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic [8*NBYTES-1:0]   i_a0,
  input  logic [8*NBYTES-1:0]   i_b0,
  input  logic [8*NBYTES-1:0]   i_a1,
  input  logic [8*NBYTES-1:0]   i_b1,
  input  logic                  i_cin0,
  input  logic                  i_cin1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_done_id,
  output logic [8*NBYTES-1:0]   o_result,
  output logic                  o_cout,
  output logic [7:0]            o_add_a,
  output logic [7:0]            o_add_b,
  output logic                  o_add_cin,
  input  logic [7:0]            i_add_sum,
  input  logic                  i_add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_last;
  logic           r_id;
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_busy;
  logic           r_done;
  logic           r_done_id;
  logic [W-1:0]   r_result;
  logic           r_cout;

  logic           w_win1;
  logic           w_accept;
  logic           w_last_byte;
  logic [IW+2:0]  w_base;
  logic [W-1:0]   w_sum_nxt;

  // DONE evaluates requests too, so back-to-back transactions lose no cycle.
  always_comb begin
    w_win1      = i_req1 & (~i_req0 | ~r_last);
    w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && (i_req0 || i_req1);
    w_last_byte = (r_idx == LAST_IDX);
    w_base      = {r_idx, 3'b000};
    w_sum_nxt   = r_sum;
    w_sum_nxt[w_base +: 8] = i_add_sum;
    w_state_nxt = r_state;
    o_add_a     = 8'd0;
    o_add_b     = 8'd0;
    o_add_cin   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_accept ? S_RUN : S_IDLE;
      S_RUN: begin
        o_add_a   = r_a[w_base +: 8];
        o_add_b   = r_b[w_base +: 8];
        o_add_cin = r_carry;
        if (w_last_byte) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_id    <= w_win1;
        r_last  <= w_win1;
        r_a     <= w_win1 ? i_a1 : i_a0;
        r_b     <= w_win1 ? i_b1 : i_b0;
        r_carry <= w_win1 ? i_cin1 : i_cin0;
        r_idx   <= '0;
        r_gnt0  <= ~w_win1;
        r_gnt1  <= w_win1;
      end else if (r_state == S_RUN) begin
        r_sum   <= w_sum_nxt;
        r_carry <= i_add_cout;
        r_idx   <= r_idx + 1'b1;
        if (w_last_byte) begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
          r_result  <= w_sum_nxt;
          r_cout    <= i_add_cout;
        end
      end
    end
  end

  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_result  = r_result;
  assign o_cout    = r_cout;

endmodule

// File: tb/tb_add_share_seq.sv
// Scoreboard bench for add_share_seq: random and directed requests against an arithmetic model,
// with an ideal 8-bit adder attached to the shared adder port.
module tb_add_share_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         cin0 = 1'b0, cin1 = 1'b0;
  logic         gnt0, gnt1, busy, done, done_id, cout;
  logic [W-1:0] result;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  add_share_seq #(.NBYTES(NB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1), .i_cin0(cin0), .i_cin1(cin1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_busy(busy), .o_done(done), .o_done_id(done_id),
    .o_result(result), .o_cout(cout), .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_sum(add_sum), .i_add_cout(add_cout)
  );

  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  typedef struct { bit id; logic [W-1:0] res; logic cout; bit gap; } sb_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic cin; } op_t;
  sb_t sb_q[$];
  op_t op_q[$];
  int  dt_q[$];

  int n_cmp = 0, n_err = 0, cyc = 0, prev_done = -100;
  always @(posedge clk) cyc <= cyc + 1;

  // reference state: arbitration history, pending requests, last reported result
  bit           m_last = 1'b1, p0 = 1'b0, p1 = 1'b0, b2b = 1'b0;
  logic [W-1:0] pa0, pb0, pa1, pb1;
  logic         pc0, pc1;
  bit           hid = 1'b0;
  logic [W-1:0] hres = '0;
  logic         hcout = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [W:0] m, t;
    m = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
    t = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);
    return t[8 * k];
  endfunction

  task automatic raise(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (!who) begin
      req0 = 1'b1; a0 = a; b0 = b; cin0 = c; p0 = 1'b1; pa0 = a; pb0 = b; pc0 = c;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; cin1 = c; p1 = 1'b1; pa1 = a; pb1 = b; pc1 = c;
    end
  endtask

  // Predict the winner, queue its expected response, then wait for its grant.
  task automatic serve();
    bit w, got;
    op_t o;
    sb_t e;
    logic [W:0] s;
    w = (p0 && p1) ? !m_last : p1;
    o.a = w ? pa1 : pa0; o.b = w ? pb1 : pb0; o.cin = w ? pc1 : pc0;
    s = {1'b0, o.a} + {1'b0, o.b} + (W+1)'(o.cin);
    e.id = w; e.res = s[W-1:0]; e.cout = s[W]; e.gap = b2b;
    sb_q.push_back(e);
    op_q.push_back(o);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL grant_timeout: got no grant expected grant to %0d", w);
    end else chk("gnt_id", 64'({gnt1, gnt0}), w ? 64'd2 : 64'd1);
    m_last = w;
    if (!w) begin p0 = 1'b0; req0 = 1'b0; a0 = rnd(); b0 = rnd(); cin0 = 1'($urandom_range(0, 1)); end
    else    begin p1 = 1'b0; req1 = 1'b0; a1 = rnd(); b1 = rnd(); cin1 = 1'($urandom_range(0, 1)); end
    b2b = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy expected idle");
    end else chk("idle_add_port", 64'({add_a, add_b, add_cin}), 64'd0);
    b2b = 1'b0;
  endtask

  // done monitor: pops the scoreboard on every done pulse, checks held values otherwise
  initial begin : done_mon
    sb_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done @cycle %0d: got done expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", 64'(done_id), 64'(e.id));
          chk("result", 64'(result), 64'(e.res));
          chk("cout", 64'(cout), 64'(e.cout));
          if (dt_q.size() > 0) chk("done_time", 64'(cyc), 64'(dt_q.pop_front()));
          if (e.gap) chk("done_gap", 64'(cyc - prev_done), 64'(NB + 1));
          hid = e.id; hres = e.res; hcout = e.cout;
        end
        prev_done = cyc;
      end else begin
        chk("held_outputs", 64'({done_id, cout, result}), 64'({hid, hcout, hres}));
      end
    end
  end

  // adder-port monitor: byte slices and carry chain for each granted transaction
  initial begin : port_mon
    op_t o;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && (gnt0 || gnt1)) begin
        if (op_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_gnt @cycle %0d: got grant expected none", cyc);
        end else begin
          o = op_q.pop_front();
          dt_q.push_back(cyc + NB);
          chk("busy_run", 64'(busy), 64'd1);
          ab = 1'b0;
          for (int k = 0; k < NB && !ab; k++) begin
            if (k > 0) begin
              @(negedge clk);
              if (!rst_n) ab = 1'b1;
            end
            if (!ab) begin
              chk("add_a", 64'(add_a), 64'(o.a[8*k +: 8]));
              chk("add_b", 64'(add_b), 64'(o.b[8*k +: 8]));
              chk("add_cin", 64'(add_cin), 64'(carry_into(o.a, o.b, o.cin, k)));
              if (k == 1) chk("gnt_pulse", 64'({gnt0, gnt1}), 64'd0);
            end
          end
          if (!ab) begin
            @(negedge clk);
            if (rst_n) begin
              chk("done_add_port", 64'({add_a, add_b, add_cin}), 64'd0);
              chk("busy_done", 64'(busy), 64'd1);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outs", 64'({gnt0, gnt1, busy, done, done_id, cout, add_a, add_b, add_cin}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single requester 0, carry ripples across a byte boundary; operands change after grant
    raise(1'b0, W'(32'h000000FF), W'(32'h00000001), 1'b0);
    serve();
    a0 = W'(32'h12345678);
    wait_idle();

    // requester 1, all-ones plus carry-in
    raise(1'b1, W'(32'hFFFFFFFF), W'(32'h00000000), 1'b1);
    serve();
    wait_idle();

    // both held high: alternating 0,1,0,1 back-to-back
    raise(1'b0, W'(32'h11112222), W'(32'h33334444), 1'b0);
    raise(1'b1, W'(32'hA5A5A5A5), W'(32'h5A5A5A5B), 1'b0);
    serve();
    raise(1'b0, W'(32'h0F0F0F0F), W'(32'hF0F0F0F1), 1'b1);
    serve();
    raise(1'b1, W'(32'h80000000), W'(32'h80000000), 1'b1);
    serve();
    serve();
    wait_idle();

    // reset in the third RUN cycle aborts; requester 0 wins the first tie afterwards
    raise(1'b0, rnd(), rnd(), 1'b1);
    serve();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({gnt0, gnt1, busy, done, done_id, cout, add_a, add_b, add_cin}), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    sb_q.delete(); op_q.delete(); dt_q.delete();
    m_last = 1'b1; hid = 1'b0; hres = '0; hcout = 1'b0; b2b = 1'b0;
    req0 = 1'b0; req1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    raise(1'b1, rnd(), rnd(), 1'b0);
    raise(1'b0, rnd(), rnd(), 1'b1);
    serve();
    serve();
    wait_idle();

    // byte sequencing
    raise(1'b0, W'(32'h04030201), W'(32'h40302010), 1'b0);
    serve();
    wait_idle();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!p0 && !p1 && ($urandom_range(0, 2) == 0)) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if (!p0 && ($urandom_range(0, 1) == 1)) raise(1'b0, rnd(), rnd(), 1'($urandom_range(0, 1)));
      if (!p1 && ($urandom_range(0, 1) == 1)) raise(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
      if (!p0 && !p1) raise(1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)));
      serve();
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
